// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
// Imported by the top level and the divide step.
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int TAG_W_DEF = 5;
    localparam int ITER      = WIDTH_DEF;

    localparam logic [4:0] ALU_OP_MUL = 5'b00110;
    localparam logic [4:0] ALU_OP_DIV = 5'b00111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multdiv_unit_div_nr_step.sv
// One non-restoring division iteration on the {remainder, quotient} pair.
// Purely combinational; the top reuses it on every RUN cycle.
module div_nr_step
    import multdiv_pkg::*;
#(
    parameter int W = WIDTH_DEF
) (
    input  logic [W:0]   rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_next,
    output logic [W-1:0] quo_next
);

    logic [W+1:0] shifted;
    logic [W+1:0] dext;
    logic [W+1:0] sum;

    // Sign of the running remainder picks subtract (>=0) or add-back (<0).
    always_comb begin
        shifted  = {rem, quo[W-1]};
        dext     = {2'b00, divisor};
        sum      = rem[W] ? (shifted + dext) : (shifted - dext);
        rem_next = sum[W:0];
        quo_next = {quo[W-2:0], ~sum[W]};
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide engine with fixed WIDTH-cycle latency.
// Operates on magnitudes and applies sign fix-up on the final iteration.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = ITER,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [TAG_W-1:0] in_rd,
    output logic             busy,
    output logic             result_RDY,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic [TAG_W-1:0] out_rd
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] count;
    logic             op_mul;
    logic             neg;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opd;
    logic [TAG_W-1:0] rd_q;

    logic             start;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     hi_mul;
    logic [WIDTH-1:0]   lo_mul;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic               mul_exc;

    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] quo_s;

    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;

    assign start      = ctrl_MULT | ctrl_DIV;
    assign accept     = start && (state != S_RUN);
    assign last       = (state == S_RUN) && (count == LAST);
    assign busy       = (state == S_RUN);
    assign result_RDY = (state == S_DONE);

    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Shift-add: {hi, lo} holds partial product above the unconsumed multiplier bits.
    assign mul_sum = {1'b0, hi[WIDTH-1:0]} + (lo[0] ? {1'b0, opd} : '0);
    assign hi_mul  = {1'b0, mul_sum[WIDTH:1]};
    assign lo_mul  = {mul_sum[0], lo[WIDTH-1:1]};
    assign prod    = {hi_mul[WIDTH-1:0], lo_mul};
    assign prod_s  = neg ? -prod : prod;
    assign mul_exc = prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};

    div_nr_step #(
        .W(WIDTH)
    ) u_step (
        .rem      (hi),
        .quo      (lo),
        .divisor  (opd),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    assign quo_s   = neg ? -quo_n : quo_n;
    assign step_hi = op_mul ? hi_mul : rem_n;
    assign step_lo = op_mul ? lo_mul : quo_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (accept) state_next = S_RUN;
            S_RUN:  if (last) state_next = S_DONE;
            S_DONE: state_next = accept ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count          <= '0;
            op_mul         <= 1'b0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            hi             <= '0;
            lo             <= '0;
            opd            <= '0;
            rd_q           <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            out_rd         <= '0;
        end else if (accept) begin
            count    <= '0;
            op_mul   <= ctrl_MULT;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == MIN_NEG) && (data_operandB == '1);
            hi       <= '0;
            lo       <= ctrl_MULT ? b_mag : a_mag;
            opd      <= ctrl_MULT ? a_mag : b_mag;
            rd_q     <= in_rd;
        end else if (busy) begin
            hi <= step_hi;
            lo <= step_lo;
            if (!last) begin
                count <= count + 1'b1;
            end else begin
                out_rd <= rd_q;
                // Divide-by-zero still burns the full latency; result forced here.
                if (op_mul) begin
                    data_result    <= prod_s[WIDTH-1:0];
                    data_exception <= mul_exc;
                end else if (div_zero) begin
                    data_result    <= '0;
                    data_exception <= 1'b1;
                end else begin
                    data_result    <= quo_s;
                    data_exception <= div_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [4:0]  in_rd = '0;
    logic        busy;
    logic        result_RDY;
    logic [31:0] data_result;
    logic        data_exception;
    logic [4:0]  out_rd;

    int vectors = 0;
    int miscompares = 0;

    multdiv_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .in_rd          (in_rd),
        .busy           (busy),
        .result_RDY     (result_RDY),
        .data_result    (data_result),
        .data_exception (data_exception),
        .out_rd         (out_rd)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input bit mul, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint sa;
        longint sb;
        longint p;
        logic [63:0] pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (mul) begin
            p  = sa * sb;
            pv = p;
            r  = pv[31:0];
            e  = pv[63:32] != {32{pv[31]}};
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            p  = sa / sb;
            pv = p;
            r  = pv[31:0];
            e  = 1'b0;
        end
    endfunction

    function automatic logic [31:0] rnd_opnd();
        int v;
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: begin
                v = int'($urandom_range(0, 40)) - 20;
                return 32'(v);
            end
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input bit mul, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd);
        ctrl_MULT     = mul;
        ctrl_DIV      = !mul;
        data_operandA = a;
        data_operandB = b;
        in_rd         = rd;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        in_rd         = 5'($urandom);
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!result_RDY && lat < 64) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op(input string tag, input bit mul,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input int from);
        int lat;
        logic [31:0] r;
        logic e;
        wait_done(from, lat);
        model(mul, a, b, r, e);
        check({tag, " latency"}, 64'(lat), 64'd32);
        check({tag, " result"}, 64'(data_result), 64'(r));
        check({tag, " exception"}, 64'(data_exception), 64'(e));
        check({tag, " out_rd"}, 64'(out_rd), 64'(rd));
    endtask

    task automatic run_op(input string tag, input bit mul,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        start_op(mul, a, b, rd);
        check({tag, " busy"}, 64'(busy), 64'd1);
        finish_op(tag, mul, a, b, rd, 0);
    endtask

    initial begin
        int seen;
        bit mul;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0] rd;

        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset rdy", 64'(result_RDY), 64'd0);
        check("reset result", 64'(data_result), 64'd0);
        check("reset exc", 64'(data_exception), 64'd0);
        check("reset rd", 64'(out_rd), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        run_op("mul 7*-6", 1'b1, 32'd7, 32'hFFFF_FFFA, 5'd1);
        run_op("mul ovf", 1'b1, 32'h0001_0000, 32'h0001_0000, 5'd2);
        run_op("div -7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd3);
        run_op("div 100/0", 1'b0, 32'd100, 32'd0, 5'd4);
        run_op("div min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        run_op("mul min*min", 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd7);

        // Divide pulse while a multiply is in flight must be ignored.
        start_op(1'b1, 32'd1234, 32'hFFFF_F000, 5'd5);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        ctrl_DIV      = 1'b1;
        data_operandB = 32'd0;
        in_rd         = 5'd9;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        check("ignored start busy", 64'(busy), 64'd1);
        finish_op("mid pulse", 1'b1, 32'd1234, 32'hFFFF_F000, 5'd5, 10);

        // Back-to-back: start issued in the DONE cycle.
        start_op(1'b0, 32'd1000, 32'hFFFF_FFF9, 5'd11);
        check("b2b busy", 64'(busy), 64'd1);
        finish_op("b2b div", 1'b0, 32'd1000, 32'hFFFF_FFF9, 5'd11, 0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
            mul = 1'($urandom);
            a   = rnd_opnd();
            b   = rnd_opnd();
            rd  = 5'($urandom);
            run_op($sformatf("rnd%0d %s %0h %0h", i, mul ? "mul" : "div", a, b),
                   mul, a, b, rd);
        end

        // Reset mid-run aborts with no result pulse afterwards.
        start_op(1'b1, 32'd5, 32'd9, 5'd13);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort rdy", 64'(result_RDY), 64'd0);
        check("abort result", 64'(data_result), 64'd0);
        check("abort exc", 64'(data_exception), 64'd0);
        check("abort rd", 64'(out_rd), 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (result_RDY || busy) seen++;
        end
        check("no pulse after abort", 64'(seen), 64'd0);

        run_op("post reset mul", 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5'd14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
